// File: rtl/noc_injector.sv
// noc_injector: source-side NoC network interface.
// Buffers multiplier result words in a local FIFO and drives them, one per
// cycle, onto an arbiter-tree leaf as {val, addr, data} packets while
// honouring the leaf's stall back-pressure.
// Optional feature macro: NOC_INJ_AUTO_ADDR_EN. When defined, in_addr is
// ignored and an internal wrapping counter supplies each pushed word's address.
module noc_injector #(
   parameter int bit_width    = 16,
   parameter int log_n_add    = 6,
   parameter int ctrl_bit     = 1,
   parameter int log_buff_len = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   input  logic [bit_width-1:0]                  in_data,
   input  logic [log_n_add-1:0]                  in_addr,
   output logic                                  in_ready,
   output logic [ctrl_bit+log_n_add+bit_width-1:0] pkt,
   input  logic                                  stall,
   output logic [log_buff_len:0]                 level
);

   localparam int DEPTH = 1 << log_buff_len;
   localparam int EW    = log_n_add + bit_width;
   localparam int PW    = ctrl_bit + EW;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   logic [EW-1:0]         mem_q [DEPTH];
   logic [log_buff_len:0] wr_ptr_q, wr_ptr_d;
   logic [log_buff_len:0] rd_ptr_q, rd_ptr_d;
   logic [log_buff_len:0] level_q, level_d;
   state_t                state_q;
   logic [PW-1:0]         pkt_q;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic [log_n_add-1:0]  push_addr;
   logic [EW-1:0]         head;

   // Full/empty from registered pointers only, so in_ready never depends on stall.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[log_buff_len] != rd_ptr_q[log_buff_len]) &&
                       (wr_ptr_q[log_buff_len-1:0] == rd_ptr_q[log_buff_len-1:0]);
   assign in_ready   = !fifo_full;

   // A pop feeds pkt: from IDLE whenever data waits, from SEND only once the
   // current packet is consumed.
   assign push = in_valid && !fifo_full;
   assign pop  = !fifo_empty && ((state_q == IDLE) || !stall);
   assign head = mem_q[rd_ptr_q[log_buff_len-1:0]];

`ifdef NOC_INJ_AUTO_ADDR_EN
   logic [log_n_add-1:0] addr_cnt_q;
   logic                 unused_in_addr;

   assign unused_in_addr = ^in_addr;
   assign push_addr      = addr_cnt_q;

   // Striding address counter: advances on every accepted word, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_cnt_q <= '0;
      end else if (push) begin
         addr_cnt_q <= addr_cnt_q + 1'b1;
      end
   end
`else
   assign push_addr = in_addr;
`endif

   // Next pointer and occupancy values from this cycle's push/pop decisions.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; the pointers alone
      // define which entries are valid, and this lets it map onto RAM.
      if (!rst && push) begin
         mem_q[wr_ptr_q[log_buff_len-1:0]] <= {push_addr, in_data};
      end
   end

   // Output packet FSM: loads the FIFO head, holds it under stall, clears when drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pkt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  pkt_q   <= {ctrl_bit'(1), head};
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (!stall) begin
                  if (!fifo_empty) begin
                     pkt_q <= {ctrl_bit'(1), head};
                  end else begin
                     pkt_q   <= '0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               pkt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign pkt   = pkt_q;
   assign level = level_q;

endmodule

// File: tb/tb_noc_injector.sv
// Directed self-checking bench for noc_injector. A scoreboard queue receives
// the expected packet for every accepted word and is popped whenever the DUT
// presents a packet that the leaf consumes (val = 1, stall = 0).
module tb_noc_injector;

   localparam int BW  = 16;
`ifdef NOC_INJ_AUTO_ADDR_EN
   localparam int LNA = 2;
`else
   localparam int LNA = 6;
`endif
   localparam int LBL = 3;
   localparam int PW  = 1 + LNA + BW;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic [BW-1:0]  in_data;
   logic [LNA-1:0] in_addr;
   logic           in_ready;
   logic [PW-1:0]  pkt;
   logic           stall;
   logic [LBL:0]   level;

   logic [PW-1:0]  sb_q [$];
   logic [LNA-1:0] auto_cnt;
   logic [PW-1:0]  prev_pkt;
   logic           prev_hold;
   int             checks = 0;
   int             errors = 0;
   int             n_push;

   noc_injector #(
      .bit_width   (BW),
      .log_n_add   (LNA),
      .ctrl_bit    (1),
      .log_buff_len(LBL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_valid(in_valid),
      .in_data (in_data),
      .in_addr (in_addr),
      .in_ready(in_ready),
      .pkt     (pkt),
      .stall   (stall),
      .level   (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: score the packet/push at the negedge, then advance past the posedge.
   task automatic tick();
      logic [LNA-1:0] a;
      @(negedge clk);
      if (rst) begin
         sb_q.delete();
         auto_cnt  = '0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) check("stable_under_stall", pkt, prev_pkt);
         if (pkt[PW-1] && !stall) begin
            if (sb_q.size() == 0) check("unexpected_pkt", pkt, '0);
            else                  check("pkt_order", pkt, sb_q.pop_front());
         end
         prev_hold = pkt[PW-1] && stall;
         prev_pkt  = pkt;
         if (in_valid && in_ready) begin
`ifdef NOC_INJ_AUTO_ADDR_EN
            a = auto_cnt;
`else
            a = in_addr;
`endif
            sb_q.push_back({1'b1, a, in_data});
            auto_cnt = auto_cnt + 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [LNA-1:0] a_first;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0; stall = 1'b0;
      auto_cnt = '0; prev_hold = 1'b0; prev_pkt = '0;

      // Reset state
      repeat (3) tick();
      check("rst_pkt", pkt, '0);
      check("rst_level", level, '0);
      rst = 1'b0;
      tick();
      check("post_rst_ready", in_ready, 1);
      check("post_rst_pkt", pkt, '0);

      // Single word: 2-edge latency, no bypass
`ifdef NOC_INJ_AUTO_ADDR_EN
      a_first = '0;
`else
      a_first = LNA'(5);
`endif
      in_valid = 1'b1; in_data = 16'h1234; in_addr = LNA'(5);
      tick();
      in_valid = 1'b0;
      check("single_no_bypass", pkt, '0);
      check("single_level1", level, 1);
      tick();
      check("single_pkt", pkt, {1'b1, a_first, 16'h1234});
      check("single_level0", level, 0);
      tick();
      check("single_clear", pkt, '0);
      check("single_level_end", level, 0);

      // Stream of 20 back-to-back words
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_data = BW'($urandom); in_addr = LNA'($urandom);
         check("stream_ready", in_ready, 1);
         check("stream_level_le1", (level <= 1), 1);
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      check("stream_drained", sb_q.size(), 0);
      check("stream_level0", level, 0);

      // Back-pressure fill with stall held
      stall = 1'b1; in_valid = 1'b1; in_addr = LNA'(3); n_push = 0;
      for (int i = 0; i < 20 && in_ready; i++) begin
         in_data = BW'(16'hA000 + i);
         tick();
         n_push++;
      end
      check("bp_push_count", n_push, 9);
      check("bp_level_full", level, 8);
      check("bp_ready_low", in_ready, 0);
      check("bp_held_words", sb_q.size(), 9);
      check("bp_head", pkt, sb_q[0]);
      repeat (3) tick();
      check("bp_level_still", level, 8);
      in_valid = 1'b0; stall = 1'b0;
      repeat (12) tick();
      check("bp_drained", sb_q.size(), 0);
      check("bp_level0", level, 0);
      check("bp_pkt_clear", pkt, '0);

      // Stall toggling with random pushes
      for (int i = 0; i < 60; i++) begin
         stall = i[0];
         in_valid = 1'($urandom_range(0, 1));
         in_data = BW'($urandom); in_addr = LNA'($urandom);
         tick();
      end
      stall = 1'b0; in_valid = 1'b0;
      repeat (12) tick();
      check("toggle_drained", sb_q.size(), 0);
      check("toggle_level0", level, 0);

      // Reset mid-operation
      stall = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = BW'(16'hC000 + i); in_addr = LNA'(i);
         tick();
      end
      in_valid = 1'b0;
      check("midrst_level5", level, 5);
      check("midrst_val", pkt[PW-1], 1);
      rst = 1'b1;
      tick();
      check("midrst_pkt0", pkt, '0);
      check("midrst_level0", level, 0);
      rst = 1'b0; stall = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("midrst_no_old", pkt, '0);
      end
      check("midrst_level_end", level, 0);

`ifdef NOC_INJ_AUTO_ADDR_EN
      // Auto address: 0,1,2,3,0,1 regardless of in_addr
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = BW'(i); in_addr = LNA'($urandom);
         tick();
         if (i > 0) check("auto_addr", pkt[BW +: LNA], LNA'((i - 1) % 4));
      end
      in_valid = 1'b0;
      tick();
      check("auto_addr_last", pkt[BW +: LNA], LNA'(1));
      repeat (3) tick();
      check("auto_drained", sb_q.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
